// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem addressing, registered output with valid/ready
//
// Purpose: owns the program counter, addresses the instruction memory
// (combinational read), captures the returned word into an output register
// and hands it to decode with a valid/ready handshake. Aligned redirects
// flush and retarget the PC; a misaligned redirect halts fetch until reset.
//
// Optional feature macro: FETCH_PERF_CNT_EN (adds perf_fetched / perf_stall).
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   imem_addr         word address to instruction memory (pc[ADDR_W+1:2])
//   imem_instr        instruction word returned for imem_addr
//   redirect_valid    take redirect_pc as the next PC
//   redirect_pc       redirect target byte address
//   out_valid         out_instr/out_pc/out_pc_plus4 hold a fetched instruction
//   out_ready         decode accepts the output this cycle
//   out_instr         fetched instruction
//   out_pc            byte address of out_instr
//   out_pc_plus4      out_pc + 4 (mod 2^32)
//   misalign_err      sticky; a redirect target was not word aligned
//   perf_fetched      (FETCH_PERF_CNT_EN) count of captures
//   perf_stall        (FETCH_PERF_CNT_EN) count of backpressured FETCH cycles
module fetch_unit #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_pc_plus4,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
`endif
  output logic              misalign_err
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;
  logic [31:0] opc4_q, opc4_d;
  logic        err_q, err_d;
  logic        capture;
  logic        stall_cycle;
  logic        slot_free;

  assign slot_free = !valid_q || out_ready;
  assign imem_addr = pc_q[ADDR_W+1:2];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    opc_d       = opc_q;
    opc4_d      = opc4_q;
    err_d       = err_q;
    capture     = 1'b0;
    stall_cycle = 1'b0;

    case (state_q)
      ST_BOOT: begin
        // No capture in the boot cycle, but a redirect still steers the PC.
        state_d = ST_FETCH;
        if (redirect_valid) begin
          if (redirect_pc[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_d = redirect_pc;
          end
        end
      end
      ST_FETCH: begin
        if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
          valid_d = 1'b0;
        end else if (redirect_valid) begin
          // Flush: whatever sits in the output register is wrong-path or
          // already consumed this cycle; either way it is dropped.
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (slot_free) begin
          capture = 1'b1;
          instr_d = imem_instr;
          opc_d   = pc_q;
          opc4_d  = pc_q + 32'd4;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
        end else begin
          stall_cycle = 1'b1;
        end
      end
      default: begin
        state_d = ST_HALT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      opc_q   <= 32'd0;
      opc4_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      opc4_q  <= opc4_d;
      err_q   <= err_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_instr    = instr_q;
  assign out_pc       = opc_q;
  assign out_pc_plus4 = opc4_q;
  assign misalign_err = err_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= 32'd0;
      stall_q   <= 32'd0;
    end else begin
      if (capture)     fetched_q <= fetched_q + 32'd1;
      if (stall_cycle) stall_q   <= stall_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`else
  logic unused_perf;
  assign unused_perf = capture ^ stall_cycle;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [5:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  logic [31:0] mem [64];
  int          n_cmp;
  int          n_err;

  assign imem_instr = mem[imem_addr];

  fetch_unit #(.ADDR_W(6), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
`endif
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;

    rst            = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_pc4", out_pc_plus4, 32'd0);
    check("rst_err", {31'd0, misalign_err}, 32'd0);
    check("rst_addr", {26'd0, imem_addr}, 32'd0);

    step();
    step();
    rst = 1'b0;

    // Boot: edge 1 no capture, edge 2 first instruction.
    step();
    check("boot_e1_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("boot_e2_valid", {31'd0, out_valid}, 32'd1);
    check("boot_e2_instr", out_instr, 32'h0050_0093);
    check("boot_e2_pc", out_pc, 32'h0);
    check("boot_e2_pc4", out_pc_plus4, 32'h4);
    step();
    check("boot_e3_instr", out_instr, 32'h00A0_0113);
    check("boot_e3_pc", out_pc, 32'h4);

    // Backpressure for three edges.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_pc", out_pc, 32'h4);
      check("bp_instr", out_instr, 32'h00A0_0113);
      check("bp_addr", {26'd0, imem_addr}, 32'd2);
    end
`ifdef FETCH_PERF_CNT_EN
    check("perf_stall", perf_stall, 32'd3);
    check("perf_fetched", perf_fetched, 32'd2);
`endif
    out_ready = 1'b1;
    step();
    check("bp_release_pc", out_pc, 32'h8);
    check("bp_release_instr", out_instr, 32'hA000_0002);

    // Aligned redirect with a valid output: one bubble.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    step();
    redirect_valid = 1'b0;
    check("redir_bubble", {31'd0, out_valid}, 32'd0);
    step();
    check("redir_valid", {31'd0, out_valid}, 32'd1);
    check("redir_pc", out_pc, 32'h20);
    check("redir_instr", out_instr, 32'hA000_0008);
    check("redir_pc4", out_pc_plus4, 32'h24);

    // Word-address aliasing across the top of a 64-word memory.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFC;
    step();
    redirect_valid = 1'b0;
    check("alias_addr63", {26'd0, imem_addr}, 32'd63);
    step();
    check("alias_pc_fc", out_pc, 32'hFC);
    check("alias_instr63", out_instr, 32'hA000_003F);
    check("alias_addr0", {26'd0, imem_addr}, 32'd0);
    step();
    check("alias_pc_100", out_pc, 32'h100);
    check("alias_instr0", out_instr, 32'h0050_0093);

    // 32-bit PC wrap.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    check("wrap_pc", out_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", out_pc_plus4, 32'h0);
    check("wrap_instr", out_instr, 32'hA000_003F);

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    step();
    check("stall_pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_addr", {26'd0, imem_addr}, 32'd0);
    check("async_rst_pc", out_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("async_rst_perf", perf_stall, 32'd0);
`endif
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("reboot_pc", out_pc, 32'h0);
    check("reboot_valid", {31'd0, out_valid}, 32'd1);

    // Misaligned redirect halts; later inputs are ignored.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h22;
    step();
    check("mis_err", {31'd0, misalign_err}, 32'd1);
    check("mis_valid", {31'd0, out_valid}, 32'd0);
    redirect_pc = 32'h40;
    for (int i = 0; i < 4; i++) begin
      out_ready      = i[0];
      redirect_valid = i[1];
      step();
      check("halt_valid", {31'd0, out_valid}, 32'd0);
      check("halt_err", {31'd0, misalign_err}, 32'd1);
      check("halt_addr", {26'd0, imem_addr}, 32'd1);
    end
    redirect_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("halt_rst_err", {31'd0, misalign_err}, 32'd0);
    step();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
